// File: rtl/apb_console_writer.sv
// APB initiator for the simulation console: buffers bytes from a valid/ready stream in a
// FIFO and issues one APB write per byte, with wait-state timeout and sticky error reporting.
module apb_console_writer #(
   parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [31:0] paddr_o,
   output logic [31:0] pwdata_o,
   input  logic        pready_i,
   input  logic        pslverr_i,
   output logic        busy_o,
   output logic        err_o,
   input  logic        err_clr_i
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(TIMEOUT);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
   localparam logic [CW-1:0] WAIT_ONE = CW'(1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [AW:0]   w_count;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [CW-1:0] r_wait;
   logic          r_err;
   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_err_set;
   logic          w_psel;
   logic          w_penable;
   logic          w_timeout;

   assign w_count   = r_wr_ptr - r_rd_ptr;
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push    = byte_valid_i & ~w_full;
   assign w_timeout = ~pready_i && (r_wait == WAIT_MAX);

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_err_set    = 1'b0;
      w_psel       = 1'b0;
      w_penable    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) w_state_next = S_SETUP;
         end
         S_SETUP: begin
            w_psel       = 1'b1;
            w_state_next = S_ACCESS;
         end
         S_ACCESS: begin
            w_psel    = 1'b1;
            w_penable = 1'b1;
            if (pready_i) begin
               w_pop     = 1'b1;
               w_err_set = pslverr_i;
               // occupancy after this edge: one popped, plus any byte pushed alongside
               w_state_next = ((w_count > PTR_ONE) || w_push) ? S_SETUP : S_IDLE;
            end else if (w_timeout) begin
               w_pop        = 1'b1;
               w_err_set    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_wait   <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_err_set)      r_err <= 1'b1;
         else if (err_clr_i) r_err <= 1'b0;
         if (w_state_next == S_SETUP)
            r_wait <= '0;
         else if ((r_state == S_ACCESS) && !pready_i && (r_wait != WAIT_MAX))
            r_wait <= r_wait + WAIT_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= byte_data_i;
   end

   assign byte_ready_o = ~w_full;
   assign psel_o       = w_psel;
   assign penable_o    = w_penable;
   assign pwrite_o     = 1'b1;
   assign paddr_o      = w_psel ? CONSOLE_ADDR : '0;
   assign pwdata_o     = w_psel ? {24'h0, r_mem[r_rd_ptr[AW-1:0]]} : '0;
   assign busy_o       = ~w_empty | (r_state != S_IDLE);
   assign err_o        = r_err;

endmodule

// File: tb/tb_apb_console_writer.sv
// Self-checking bench for apb_console_writer: directed scenarios plus a random phase,
// all judged by a queue-based reference model sampled on the falling clock edge.
module tb_apb_console_writer;

   localparam logic [31:0] ADDR  = 32'h1000_0000;
   localparam int          DEPTH = 8;
   localparam int          TMO   = 64;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_data_i = 8'h00;
   logic        byte_ready_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] paddr_o;
   logic [31:0] pwdata_o;
   logic        pready_i = 1'b1;
   logic        pslverr_i = 1'b0;
   logic        busy_o;
   logic        err_o;
   logic        err_clr_i = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [7:0] mq[$];
   logic [7:0] wr_log[$];
   bit         m_err = 1'b0;
   bit         exp_setup = 1'b0;
   bit         exp_access = 1'b0;
   int         wcnt = 0;
   int         drops = 0;
   int         psel_cyc = 0;
   int         pen_cyc = 0;

   apb_console_writer #(
      .CONSOLE_ADDR(ADDR),
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT     (TMO)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .byte_valid_i(byte_valid_i),
      .byte_data_i (byte_data_i),
      .byte_ready_o(byte_ready_o),
      .psel_o      (psel_o),
      .penable_o   (penable_o),
      .pwrite_o    (pwrite_o),
      .paddr_o     (paddr_o),
      .pwdata_o    (pwdata_o),
      .pready_i    (pready_i),
      .pslverr_i   (pslverr_i),
      .busy_o      (busy_o),
      .err_o       (err_o),
      .err_clr_i   (err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: predicts the effect of the coming rising edge from stable values.
   always @(negedge clk_i) begin : monitor
      bit can_push;
      bit done;
      bit drop;
      bit pre_ne;
      if (rst_i) begin
         mq.delete();
         m_err      = 1'b0;
         wcnt       = 0;
         exp_setup  = 1'b0;
         exp_access = 1'b0;
         chk("rst_psel", {psel_o, penable_o}, 2'b00);
         chk("rst_busy", busy_o, 1'b0);
         chk("rst_err", err_o, 1'b0);
      end else begin
         pre_ne = (mq.size() != 0);
         chk("ready", byte_ready_o, mq.size() < DEPTH);
         chk("busy", busy_o, pre_ne || psel_o);
         chk("err", err_o, m_err);
         chk("pwrite", pwrite_o, 1'b1);
         if (exp_setup)  chk("enter_setup", {psel_o, penable_o}, 2'b10);
         if (exp_access) chk("enter_access", {psel_o, penable_o}, 2'b11);
         if (psel_o) begin
            psel_cyc++;
            chk("paddr", paddr_o, ADDR);
            chk("psel_nonempty", 32'(pre_ne), 1);
            if (pre_ne) chk("pwdata", pwdata_o, {24'h0, mq[0]});
         end else begin
            chk("penable_wo_psel", penable_o, 1'b0);
            chk("paddr_idle", paddr_o, 0);
            chk("pwdata_idle", pwdata_o, 0);
         end
         if (penable_o) pen_cyc++;

         can_push = byte_valid_i && (mq.size() < DEPTH);
         done     = psel_o && penable_o && pready_i;
         drop     = 1'b0;
         if (psel_o && penable_o && !pready_i) begin
            wcnt++;
            if (wcnt == TMO) drop = 1'b1;
         end else begin
            wcnt = 0;
         end
         if (drop) wcnt = 0;
         if ((done || drop) && pre_ne) begin
            if (done) wr_log.push_back(mq[0]);
            else      drops++;
            void'(mq.pop_front());
         end
         if (can_push) mq.push_back(byte_data_i);

         exp_access = psel_o && !penable_o;
         if (done)         exp_setup = (mq.size() != 0);
         else if (!psel_o) exp_setup = pre_ne;
         else              exp_setup = 1'b0;

         if ((done && pslverr_i) || drop) m_err = 1'b1;
         else if (err_clr_i)              m_err = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      int n = 0;
      step();
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      do begin
         @(negedge clk_i);
         n++;
      end while (!byte_ready_o && n < 500);
      if (n >= 500) chk("push_timeout", byte_ready_o, 1'b1);
      step();
      byte_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int maxn);
      int n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (busy_o && n < maxn);
      chk(tag, busy_o, 1'b0);
   endtask

   task automatic wait_penable();
      int n = 0;
      do begin
         step();
         n++;
      end while (!penable_o && n < 20);
      chk("wait_penable", penable_o, 1'b1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int base;
      int n;
      int d0;
      logic [7:0] bytes [DEPTH];

      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("reset_apb", {psel_o, penable_o}, 2'b00);
      chk("reset_paddr", paddr_o, 0);
      chk("reset_pwdata", pwdata_o, 0);
      chk("reset_busy", busy_o, 1'b0);
      chk("reset_err", err_o, 1'b0);
      chk("reset_ready", byte_ready_o, 1'b1);

      // Two zero-wait writes, with the first checked cycle by cycle for latency
      psel_cyc = 0;
      base = wr_log.size();
      push_byte(8'h48);
      @(negedge clk_i);
      chk("t1_idle", {psel_o, penable_o, busy_o}, 3'b001);
      @(negedge clk_i);
      chk("t1_setup", {psel_o, penable_o}, 2'b10);
      chk("t1_setup_data", pwdata_o, 32'h48);
      @(negedge clk_i);
      chk("t1_access", {psel_o, penable_o}, 2'b11);
      @(negedge clk_i);
      chk("t1_done", {psel_o, penable_o}, 2'b00);
      chk("t1_one_write", wr_log.size() - base, 1);
      push_byte(8'h69);
      wait_idle("t1_idle_end", 50);
      chk("t1_writes", wr_log.size() - base, 2);
      chk("t1_b0", wr_log[base], 8'h48);
      chk("t1_b1", wr_log[base+1], 8'h69);
      chk("t1_psel_cycles", psel_cyc, 4);

      // Three wait states on 'A'
      step();
      pready_i = 1'b0;
      pen_cyc = 0;
      base = wr_log.size();
      push_byte(8'h41);
      wait_penable();
      step();
      step();
      step();
      pready_i = 1'b1;
      step();
      chk("t2_penable_cycles", pen_cyc, 4);
      chk("t2_writes", wr_log.size() - base, 1);
      chk("t2_byte", wr_log[base], 8'h41);
      chk("t2_err", err_o, 1'b0);

      // Fill the FIFO behind a stalled slave, then drain
      step();
      pready_i = 1'b0;
      base = wr_log.size();
      for (int i = 0; i < DEPTH; i++) begin
         bytes[i] = 8'($urandom);
         push_byte(bytes[i]);
      end
      byte_valid_i = 1'b1;
      byte_data_i  = 8'($urandom);
      @(negedge clk_i);
      chk("t3_full_ready", byte_ready_o, 1'b0);
      step();
      byte_valid_i = 1'b0;
      pready_i = 1'b1;
      wait_idle("t3_idle", 100);
      chk("t3_writes", wr_log.size() - base, DEPTH);
      for (int i = 0; i < DEPTH; i++) chk("t3_order", wr_log[base+i], bytes[i]);

      // Slave error on byte 2 of 3, with a clear request in the same cycle
      step();
      pready_i = 1'b0;
      base = wr_log.size();
      for (int i = 0; i < 3; i++) begin
         bytes[i] = 8'($urandom);
         push_byte(bytes[i]);
      end
      for (int k = 0; k < 3; k++) begin
         wait_penable();
         pslverr_i = (k == 1);
         err_clr_i = (k == 1);
         pready_i  = 1'b1;
         step();
         pready_i  = 1'b0;
         pslverr_i = 1'b0;
         err_clr_i = 1'b0;
         chk("t4_err_after", err_o, k >= 1);
      end
      chk("t4_writes", wr_log.size() - base, 3);
      for (int i = 0; i < 3; i++) chk("t4_order", wr_log[base+i], bytes[i]);
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      chk("t4_err_cleared", err_o, 1'b0);

      // Stuck slave: abort after TMO access cycles
      pen_cyc = 0;
      base = wr_log.size();
      d0 = drops;
      push_byte(8'h5a);
      wait_penable();
      n = 0;
      while (psel_o && n < 200) begin
         step();
         n++;
      end
      chk("t5_penable_cycles", pen_cyc, TMO);
      chk("t5_err", err_o, 1'b1);
      chk("t5_idle", {psel_o, busy_o}, 2'b00);
      chk("t5_no_write", wr_log.size() - base, 0);
      chk("t5_drop", drops - d0, 1);
      pready_i = 1'b1;
      push_byte(8'h7e);
      wait_idle("t5_idle_after", 50);
      chk("t5_next_write", wr_log.size() - base, 1);
      chk("t5_next_byte", wr_log[base], 8'h7e);
      chk("t5_err_sticky", err_o, 1'b1);
      step();
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;

      // Asynchronous reset in the middle of an access
      pready_i = 1'b0;
      base = wr_log.size();
      for (int i = 0; i < 3; i++) push_byte(8'($urandom));
      wait_penable();
      #2 rst_i = 1'b1;
      #1;
      chk("t6_async_psel", {psel_o, penable_o}, 2'b00);
      chk("t6_async_busy", busy_o, 1'b0);
      step();
      step();
      rst_i = 1'b0;
      pready_i = 1'b1;
      repeat (10) step();
      chk("t6_no_write", wr_log.size() - base, 0);
      chk("t6_busy", busy_o, 1'b0);
      chk("t6_ready", byte_ready_o, 1'b1);

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         step();
         byte_valid_i = 1'($urandom_range(0, 1));
         byte_data_i  = 8'($urandom);
         pready_i     = ($urandom_range(0, 3) != 0);
         pslverr_i    = ($urandom_range(0, 7) == 0);
         err_clr_i    = ($urandom_range(0, 15) == 0);
      end
      step();
      byte_valid_i = 1'b0;
      pready_i     = 1'b1;
      pslverr_i    = 1'b0;
      err_clr_i    = 1'b0;
      wait_idle("t7_idle", 100);
      chk("t7_drained", mq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
